// File: rtl/cpu_intr_accept_pkg.sv
// Shared types, widths and the acceptance qualifier for cpu_intr_accept.
// Optional build macro: CPU_INTR_NMI_BLOCK_EN (SR.BL also blocks the non-maskable class).
package cpu_intr_pkg;

   localparam int unsigned LVL_W   = 5;
   localparam int unsigned VEC_W   = 8;
   localparam int unsigned NMI_BIT = 4;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } intr_state_e;

   // Level 0 can never beat an unsigned mask, so it is implicitly rejected.
   function automatic logic accept_f(
      input logic             req,
      input logic [LVL_W-1:0] level,
      input logic [3:0]       imask,
      input logic             bl
   );
      logic maskable_ok;
      maskable_ok = !bl && (level[3:0] > imask);
`ifdef CPU_INTR_NMI_BLOCK_EN
      return req && !bl && (level[NMI_BIT] || maskable_ok);
`else
      return req && (level[NMI_BIT] || maskable_ok);
`endif
   endfunction

endpackage

// File: rtl/cpu_intr_accept_if.sv
// Controller request/ack and pipeline exception-entry signals of one CPU's interrupt acceptor.
// master = controller/CPU side that drives the requests, slave = the acceptor.
interface cpu_intr_accept_if;
   import cpu_intr_pkg::*;

   logic             intr_req_i;
   logic [LVL_W-1:0] intr_level_i;
   logic [VEC_W-1:0] intr_vec_i;
   logic             inta_ack_o;
   logic [3:0]       sr_imask_i;
   logic             sr_bl_i;
   logic             exc_req_o;
   logic [LVL_W-1:0] exc_level_o;
   logic [VEC_W-1:0] exc_vec_o;
   logic             exc_take_i;

   modport master (
      output intr_req_i, intr_level_i, intr_vec_i, sr_imask_i, sr_bl_i, exc_take_i,
      input  inta_ack_o, exc_req_o, exc_level_o, exc_vec_o
   );

   modport slave (
      input  intr_req_i, intr_level_i, intr_vec_i, sr_imask_i, sr_bl_i, exc_take_i,
      output inta_ack_o, exc_req_o, exc_level_o, exc_vec_o
   );

endinterface

// File: rtl/cpu_intr_accept.sv
// Per-CPU interrupt acceptor: qualifies controller requests against SR, raises exception entry,
// returns a one-cycle acknowledge and then ignores requests for HOLDOFF cycles.
module cpu_intr_accept
   import cpu_intr_pkg::*;
#(
   parameter int unsigned HOLDOFF = 4
) (
   input logic               clk,
   input logic               rst,
   cpu_intr_accept_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

   intr_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic             req_q, req_d;
   logic             ack_q, ack_d;
   logic             accept_s;

   // Next-state, latch and output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lvl_d    = lvl_q;
      vec_d    = vec_q;
      accept_s = accept_f(bus.intr_req_i, bus.intr_level_i, bus.sr_imask_i, bus.sr_bl_i);

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               lvl_d   = bus.intr_level_i;
               vec_d   = bus.intr_vec_i;
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            // A take wins even if the request vanished in the same cycle.
            if (bus.exc_take_i) begin
               state_d = ACK;
            end else if (!accept_s) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
               if ((bus.intr_level_i != lvl_q) || (bus.intr_vec_i != vec_q)) begin
                  lvl_d = bus.intr_level_i;
                  vec_d = bus.intr_vec_i;
               end else begin
                  lvl_d = lvl_q;
                  vec_d = vec_q;
               end
            end
         end
         ACK: begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
         end
         HOLD: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      req_d = (state_d == REQ);
      ack_d = (state_d == ACK);
   end

   // State, counter, latched request and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         lvl_q   <= {LVL_W{1'b0}};
         vec_q   <= {VEC_W{1'b0}};
         req_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         vec_q   <= vec_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.exc_req_o   = req_q;
   assign bus.inta_ack_o  = ack_q;
   assign bus.exc_level_o = lvl_q;
   assign bus.exc_vec_o   = vec_q;

endmodule

// File: tb/tb_cpu_intr_accept.sv
// Directed bench for cpu_intr_accept with HOLDOFF=4; expectations are hand-computed cycle by cycle.
module tb_cpu_intr_accept;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   cpu_intr_accept_if bus();

   cpu_intr_accept #(.HOLDOFF(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic req, input logic ack,
                            input logic [4:0] lvl, input logic [7:0] vec);
      check_eq({tag, ".req"}, 32'(bus.exc_req_o), 32'(req));
      check_eq({tag, ".ack"}, 32'(bus.inta_ack_o), 32'(ack));
      check_eq({tag, ".lvl"}, 32'(bus.exc_level_o), 32'(lvl));
      check_eq({tag, ".vec"}, 32'(bus.exc_vec_o), 32'(vec));
   endtask

   logic nmi_expect;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
`ifdef CPU_INTR_NMI_BLOCK_EN
      nmi_expect = 1'b0;
`else
      nmi_expect = 1'b1;
`endif
      rst              = 1'b1;
      bus.intr_req_i   = 1'b0;
      bus.intr_level_i = 5'd0;
      bus.intr_vec_i   = 8'd0;
      bus.sr_imask_i   = 4'd0;
      bus.sr_bl_i      = 1'b0;
      bus.exc_take_i   = 1'b0;
      tick();
      tick();
      check_out("reset", 1'b0, 1'b0, 5'd0, 8'd0);
      rst = 1'b0;

      // Take while idle is ignored.
      bus.exc_take_i = 1'b1;
      tick();
      check_out("idle_take", 1'b0, 1'b0, 5'd0, 8'd0);
      bus.exc_take_i = 1'b0;

      // Basic accept, take, ack, holdoff.
      bus.sr_imask_i   = 4'd3;
      bus.intr_req_i   = 1'b1;
      bus.intr_level_i = 5'd5;
      bus.intr_vec_i   = 8'h41;
      tick();
      check_out("basic_req", 1'b1, 1'b0, 5'd5, 8'h41);
      bus.exc_take_i = 1'b1;
      tick();
      bus.exc_take_i = 1'b0;
      check_out("basic_ack", 1'b0, 1'b1, 5'd5, 8'h41);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq($sformatf("hold%0d.req", i), 32'(bus.exc_req_o), 32'd0);
         check_eq($sformatf("hold%0d.ack", i), 32'(bus.inta_ack_o), 32'd0);
      end
      tick();
      check_out("rearm_req", 1'b1, 1'b0, 5'd5, 8'h41);
      bus.exc_take_i = 1'b1;
      bus.intr_req_i = 1'b0;
      tick();
      bus.exc_take_i = 1'b0;
      check_eq("rearm_ack", 32'(bus.inta_ack_o), 32'd1);
      for (int i = 0; i < 6; i++) tick();

      // Masked request, then mask lowered.
      bus.sr_imask_i   = 4'd7;
      bus.intr_req_i   = 1'b1;
      bus.intr_level_i = 5'd5;
      bus.intr_vec_i   = 8'h41;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("masked%0d", i), 32'(bus.exc_req_o), 32'd0);
      end
      bus.sr_imask_i = 4'd4;
      tick();
      check_out("unmasked", 1'b1, 1'b0, 5'd5, 8'h41);

      // Reselect while pending, then withdraw via BL.
      bus.intr_level_i = 5'd9;
      bus.intr_vec_i   = 8'h50;
      tick();
      check_out("reselect", 1'b1, 1'b0, 5'd9, 8'h50);
      bus.sr_bl_i = 1'b1;
      tick();
      check_out("bl_withdraw", 1'b0, 1'b0, 5'd9, 8'h50);
      tick();
      check_out("bl_noack", 1'b0, 1'b0, 5'd9, 8'h50);

      // NMI class against BL and full mask.
      bus.sr_imask_i   = 4'd15;
      bus.intr_level_i = 5'h10;
      bus.intr_vec_i   = 8'h22;
      tick();
      check_eq("nmi_req", 32'(bus.exc_req_o), 32'(nmi_expect));
      bus.intr_req_i = 1'b0;
      tick();
      check_eq("nmi_drop", 32'(bus.exc_req_o), 32'd0);
      bus.sr_bl_i    = 1'b0;
      bus.sr_imask_i = 4'd0;

      // Request drops in the same cycle as the take.
      bus.intr_req_i   = 1'b1;
      bus.intr_level_i = 5'd3;
      bus.intr_vec_i   = 8'h77;
      tick();
      check_out("simul_req", 1'b1, 1'b0, 5'd3, 8'h77);
      bus.intr_req_i   = 1'b0;
      bus.intr_level_i = 5'd6;
      bus.intr_vec_i   = 8'h99;
      bus.exc_take_i   = 1'b1;
      tick();
      bus.exc_take_i = 1'b0;
      check_out("simul_ack", 1'b0, 1'b1, 5'd3, 8'h77);
      tick();
      check_eq("simul_ack_once", 32'(bus.inta_ack_o), 32'd0);
      for (int i = 0; i < 5; i++) tick();

      // Reset during the acknowledge cycle.
      bus.intr_req_i   = 1'b1;
      bus.intr_level_i = 5'd2;
      bus.intr_vec_i   = 8'h12;
      tick();
      check_out("rst_req", 1'b1, 1'b0, 5'd2, 8'h12);
      bus.exc_take_i = 1'b1;
      tick();
      bus.exc_take_i = 1'b0;
      check_eq("rst_ack", 32'(bus.inta_ack_o), 32'd1);
      rst            = 1'b1;
      bus.intr_req_i = 1'b0;
      tick();
      check_out("rst_in_ack", 1'b0, 1'b0, 5'd0, 8'd0);
      rst = 1'b0;
      tick();
      check_out("rst_no_replay", 1'b0, 1'b0, 5'd0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cpu_intr_accept.md
# cpu_intr_accept

Per-CPU interrupt acceptor that sits at the CPU end of the interrupt controller's request/acknowledge interface. It samples the request, level and vector from the controller and qualifies them against the CPU status register mask and block bit. It presents an exception-entry request to the CPU pipeline and returns the one-cycle acknowledge once the pipeline takes the interrupt. One instance is used per CPU.

## Interface
- HOLDOFF, 4: post-acknowledge cycles during which new requests are ignored; legal range 1..15.
- clk  input  1  CPU clock
- rst  input  1  reset; synchronous, active-high
- intr_req_i  input  1  interrupt request from the controller, held until acknowledged
- intr_level_i  input  5  request level; bit4=1 is the non-maskable class (NMI/error), [3:0] is the priority
- intr_vec_i  input  8  vector number
- inta_ack_o  output  1  acknowledge pulse to the controller
- sr_imask_i  input  4  CPU SR interrupt mask
- sr_bl_i  input  1  CPU SR block bit
- exc_req_o  output  1  exception-entry request to the pipeline
- exc_level_o  output  5  latched level
- exc_vec_o  output  8  latched vector
- exc_take_i  input  1  pipeline takes the interrupt at an instruction boundary

## Operation
- accept = intr_req_i && (intr_level_i[4] || (!sr_bl_i && intr_level_i[3:0] > sr_imask_i)). A request with intr_level_i == 0 is never accepted.
- States are IDLE, REQ, ACK and HOLD.
- IDLE: when accept is true, latch level and vector and go to REQ.
- REQ:
  - exc_take_i=1 has priority over all other conditions, including a same-cycle drop of intr_req_i. The latched values are used and the state goes to ACK.
  - If accept is false (request withdrawn, mask raised or BL set), go to IDLE. The latched values are retained but are not meaningful.
  - If accept is true and the incoming level or vector differs from the latched values, re-latch them. This handles a controller reselect.
- ACK: one cycle, then go to HOLD and load the counter with HOLDOFF-1.
- HOLD: the counter decrements each cycle and the state goes to IDLE when the counter is 0. Requests are ignored in HOLD.
- exc_req_o = (state==REQ). inta_ack_o = (state==ACK). Both are driven from registered state.
- Vector width is 8 bits, level is 5 bits, and the counter is 4 bits. The counter never underflows.

## Timing
- Reset values: inta_ack_o=0, exc_req_o=0, exc_level_o=0, exc_vec_o=0, state=IDLE, counter=0.
- Acceptable request sampled at edge N: exc_req_o=1 from cycle N+1.
- exc_take_i sampled high at edge M in REQ: inta_ack_o=1 for exactly cycle M+1, and exc_req_o=0 from M+1.
- HOLD occupies cycles M+2..M+1+HOLDOFF. The earliest new exc_req_o is cycle M+3+HOLDOFF.
- A re-latch in REQ shows on exc_level_o/exc_vec_o one cycle after the input change. exc_req_o stays high throughout.
- exc_take_i while not in REQ is ignored.
- rst asserted in any state forces IDLE next cycle. An ACK pulse in progress is truncated and no acknowledge is replayed.

## Configuration
- CPU_INTR_NMI_BLOCK_EN defined: the non-maskable class is also blocked by sr_bl_i, so accept requires !sr_bl_i for every level.
- CPU_INTR_NMI_BLOCK_EN undefined: level[4] requests ignore sr_bl_i and sr_imask_i.

## Structure
- Package cpu_intr_pkg holds:
  - the state enum (IDLE/REQ/ACK/HOLD);
  - constants LVL_W=5, VEC_W=8, NMI_BIT=4;
  - the accept function taking (req, level, imask, bl).
- No sub-module; the block is a single flat FSM plus counter.

## Test plan
- Basic accept: imask=3, bl=0, req with level=5, vec=0x41 → exc_req_o high next cycle. Take at M → ack high only at M+1 → with HOLDOFF=4, exc_req_o stays low through M+5 even if req is still high.
- Masked request: imask=7, level=5 → exc_req_o never rises. Then drop imask to 4 → exc_req_o rises one cycle later.
- Reselect and withdraw: in REQ, change to level=9, vec=0x50 → exc_vec_o=0x50 next cycle with exc_req_o continuously high. Then set bl=1 → exc_req_o drops and no ack is issued.
- NMI: bl=1, imask=15, level=0x10 → accepted when CPU_INTR_NMI_BLOCK_EN is undefined; never accepted when it is defined.
- Simultaneous events: intr_req_i drops in the same cycle as exc_take_i → ack is still issued at M+1 with the previously latched vector.
- Reset during ACK: rst in the ACK cycle → inta_ack_o=0, exc_req_o=0 and all outputs at reset values the next cycle.
